// File: rtl/mux_word_scanner.sv
// Register bank plus select-sequence generator feeding a 16:1 word mux.
// Optional registered read port enabled by MUX_WORD_SCANNER_RDPORT_EN.
module mux_word_scanner #(
    parameter int WIDTH   = 16,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  wr_en,
    input  logic [3:0]            wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [16*WIDTH-1:0]   words_out,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [3:0]            first,
    input  logic [3:0]            last,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [3:0]            sel,
    output logic                  sel_strobe,
    output logic                  busy,
`ifdef MUX_WORD_SCANNER_RDPORT_EN
    input  logic [3:0]            rd_addr,
    output logic [WIDTH-1:0]      rd_data,
`endif
    output logic                  done
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t               state_q, state_d;
    logic [3:0]           sel_q, sel_d;
    logic                 strobe_q, strobe_d;
    logic                 done_q, done_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [3:0]           first_q, first_d;
    logic [3:0]           last_q, last_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [WIDTH-1:0]     bank_q [16];
    logic [WIDTH-1:0]     bank_d [16];

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        first_d  = first_q;
        last_d   = last_q;
        dwell_d  = dwell_q;
        bank_d   = bank_q;
        if (wr_en) bank_d[wr_addr] = wr_data;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    mode_d   = mode;
                    first_d  = first;
                    last_d   = last;
                    dwell_d  = dwell;
                    sel_d    = first;
                    cnt_d    = dwell;
                    strobe_d = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                // stop beats every advance/complete decision below
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (sel_q != last_q) begin
                    sel_d    = sel_q + 4'd1;
                    cnt_d    = dwell_q;
                    strobe_d = 1'b1;
                end else if (!mode_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    sel_d    = first_q;
                    cnt_d    = dwell_q;
                    strobe_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            first_q  <= '0;
            last_q   <= '0;
            dwell_q  <= '0;
            for (int i = 0; i < 16; i++) bank_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            first_q  <= first_d;
            last_q   <= last_d;
            dwell_q  <= dwell_d;
            bank_q   <= bank_d;
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_words
        assign words_out[WIDTH*i +: WIDTH] = bank_q[i];
    end

`ifdef MUX_WORD_SCANNER_RDPORT_EN
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    // Reads the pre-write bank so a colliding write returns old data.
    always_comb rd_data_d = bank_q[rd_addr];

    always_ff @(posedge clk or posedge res) begin
        if (res) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
`endif

    assign sel        = sel_q;
    assign sel_strobe = strobe_q;
    assign done       = done_q;
    assign busy       = (state_q == HOLD);

endmodule

// File: doc/mux_word_scanner.md
Name: mux_word_scanner

Overview:
- Upstream feeder for the 16:1 16-bit word mux.
- Holds a 16-entry x 16-bit register bank and exports all 16 words in parallel as the mux data inputs.
- Generates the 4-bit select sequence from a programmable scan FSM (range, dwell, one-pass or continuous), with start/stop control and status pulses.

Parameters:
- WIDTH, 16, bits per bank word; exported words are WIDTH wide.
- DWELL_W, 8, width of the dwell counter and the dwell input.

Ports:
- clk  in  1  rising-edge clock.
- res  in  1  asynchronous active-high reset.
- wr_en  in  1  write strobe for the register bank.
- wr_addr  in  4  bank address written when wr_en=1.
- wr_data  in  WIDTH  write data.
- words_out  out  16*WIDTH  flat bank image; word i at [WIDTH*i+WIDTH-1 : WIDTH*i]; word 0 feeds mux input A, word 15 feeds mux input P.
- start  in  1  begin a scan; sampled only in IDLE.
- stop  in  1  abort the scan.
- mode  in  1  0 = one-pass, 1 = continuous; latched at start.
- first  in  4  first scan address; latched at start.
- last  in  4  last scan address; latched at start.
- dwell  in  DWELL_W  extra hold cycles per address; latched at start.
- sel  out  4  mux select.
- sel_strobe  out  1  1-cycle pulse in the cycle sel takes a new value.
- busy  out  1  high while the FSM is outside IDLE.
- done  out  1  1-cycle pulse at completion of a one-pass scan.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (res); all state is registered on clk and cleared asynchronously by res.
- Reset values: all bank words 0, sel=0, sel_strobe=0, busy=0, done=0, FSM=IDLE, dwell counter=0.
- Writes:
  - wr_en=1 updates bank[wr_addr] at the clock edge; words_out reflects it the next cycle (1-cycle latency).
  - Writes are allowed in any FSM state, including to the address currently selected.
- FSM states: IDLE, HOLD.
- IDLE:
  - start=1 and stop=0 -> latch mode, first, last, dwell; sel<=first; sel_strobe=1; cnt<=dwell; go to HOLD.
  - stop=1 in the same cycle as start -> remain in IDLE, no strobe (stop wins).
- HOLD:
  - Each address is held for dwell+1 cycles. dwell=0 -> sel advances every cycle.
  - cnt>0 -> cnt<=cnt-1.
  - cnt==0 and sel!=last -> sel<=sel+1 (mod 16, so 15 wraps to 0); cnt<=dwell; sel_strobe=1.
  - cnt==0, sel==last, mode=0 -> done=1 for one cycle; go to IDLE; sel holds at last.
  - cnt==0, sel==last, mode=1 -> sel<=first; cnt<=dwell; sel_strobe=1; stay in HOLD.
  - stop=1 in any HOLD cycle -> go to IDLE next edge; sel holds its current value; no done, no strobe. stop takes priority over advance.
  - start while busy is ignored; latched parameters are not updated.
- Range rules:
  - first>last wraps through 15->0, e.g. first=14, last=1 scans 14, 15, 0, 1.
  - first==last scans a single address.
  - A full 16-address scan uses last = first-1 (mod 16).
- busy=1 exactly while FSM=HOLD.
- sel_strobe and done are never both high in the same cycle.
- Reset mid-scan: everything returns to the reset values immediately, asynchronously; the next scan needs a fresh start.

Optional Feature:
- Macro: MUX_WORD_SCANNER_RDPORT_EN.
- Defined: adds input rd_addr[3:0] and output rd_data[WIDTH-1:0].
  - rd_data is registered: bank[rd_addr] appears 1 cycle after rd_addr is presented.
  - Same-cycle write to the same address returns the old data.
  - rd_data resets to 0.
- Undefined: both ports are absent and the bank is visible only through words_out.

Test Plan:
- Bank write/readback: reset, then write bank[i]=16'h1000+i for i=0..15 -> words_out word i = 16'h1000+i, one cycle after each write; all words 0 after reset.
- One-pass, no dwell: first=3, last=6, dwell=0, mode=0, start -> sel sequence 3,4,5,6 on consecutive cycles, each with sel_strobe; done pulses once; busy low after done; sel stays 6.
- Wrap and dwell: first=14, last=1, dwell=2, mode=0 -> sel 14,15,0,1, each held 3 cycles; 4 strobes; done after 12 HOLD cycles.
- Continuous and stop: first=0, last=2, dwell=0, mode=1 -> sel 0,1,2,0,1,... with no done; stop asserted while sel=1 -> IDLE next cycle, sel=1, busy=0, no done.
- Priority: start+stop together in IDLE -> no state change. start during HOLD -> ignored. res asserted mid-scan -> sel=0, busy=0 asynchronously, bank cleared.
- With MUX_WORD_SCANNER_RDPORT_EN: write bank[5]=16'hBEEF, then rd_addr=5 -> rd_data=16'hBEEF one cycle later. Same-cycle write of 16'h1234 to address 5 -> rd_data=16'hBEEF that cycle, 16'h1234 on the next read.
